// File: rtl/arm7_pkg.sv
// Shared definitions for the ARM7 load/store unit: FSM state encoding and
// the LDM/STM addressing modes, encoded as {up, pre}.
package arm7_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ACCESS    = 2'd1,
        ST_LOAD_WAIT = 2'd2,
        ST_DONE      = 2'd3
    } lsu_state_t;

    localparam logic [1:0] MODE_DA = 2'b00;
    localparam logic [1:0] MODE_DB = 2'b01;
    localparam logic [1:0] MODE_IA = 2'b10;
    localparam logic [1:0] MODE_IB = 2'b11;

endpackage

// File: rtl/lsu_reg_picker.sv
// Picks the lowest-numbered register still pending in an LDM/STM list and
// returns the list with that register removed.
module lsu_reg_picker (
    input  logic [15:0] list,
    output logic [3:0]  index,
    output logic [15:0] remaining
);

    // Scan from the top down so the lowest set bit is the last one written.
    always_comb begin
        index = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (list[i]) begin
                index = 4'(i);
            end
        end
    end

    assign remaining = list & (list - 16'd1);

endmodule

// File: rtl/arm7_load_store_unit.sv
// ARM7 memory-access stage: single LDR/LDRB/STR/STRB and LDM/STM sequencing
// in front of data_memory, with register-file writeback and base update.
module arm7_load_store_unit
    import arm7_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_load,
    input  logic        req_byte,
    input  logic        req_multi,
    input  logic        req_up,
    input  logic        req_pre,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_store_data,
    input  logic [3:0]  req_rd,
    input  logic [15:0] req_reglist,
    output logic [3:0]  rf_rd_addr,
    input  logic [31:0] rf_rd_data,
    output logic        wb_valid,
    output logic [3:0]  wb_reg,
    output logic [31:0] wb_data,
    output logic        done,
    output logic [31:0] base_next,
    output logic        mem_write_word_en,
    output logic        mem_write_byte_en,
    output logic        mem_read_word_en,
    output logic        mem_read_byte_en,
    output logic [31:0] mem_write_word_address,
    output logic [31:0] mem_write_byte_address,
    output logic [31:0] mem_read_word_address,
    output logic [31:0] mem_read_byte_address,
    output logic [31:0] mem_write_word_data,
    output logic [7:0]  mem_write_byte_data,
    input  logic [31:0] mem_read_word_data,
    input  logic [7:0]  mem_read_byte_data
);

    lsu_state_t  state;
    lsu_state_t  state_next;

    logic        load_q;
    logic        byte_q;
    logic        multi_q;
    logic [31:0] addr_q;
    logic [31:0] store_data_q;
    logic [3:0]  rd_q;
    logic [15:0] list_q;
    logic [3:0]  cur_reg_q;
    logic [31:0] base_next_q;

    logic [3:0]  pick_index;
    logic [15:0] pick_remaining;
    logic [4:0]  n_regs;
    logic [31:0] four_n;
    logic [31:0] base_aligned;
    logic [31:0] start_addr;

    lsu_reg_picker u_picker (
        .list      (list_q),
        .index     (pick_index),
        .remaining (pick_remaining)
    );

    // Register count of the incoming list, scaled to a byte offset.
    always_comb begin
        n_regs = 5'd0;
        for (int i = 0; i < 16; i++) begin
            n_regs = n_regs + {4'd0, req_reglist[i]};
        end
        four_n = {25'd0, n_regs, 2'b00};
    end

    // Lowest address of the block; registers always go out in ascending order.
    always_comb begin
        base_aligned = {req_addr[31:2], 2'b00};
        case ({req_up, req_pre})
            MODE_IA: start_addr = base_aligned;
            MODE_IB: start_addr = base_aligned + 32'd4;
            MODE_DA: start_addr = base_aligned - four_n + 32'd4;
            MODE_DB: start_addr = base_aligned - four_n;
            default: start_addr = base_aligned;
        endcase
    end

    // State register; reset abandons any transfer in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: stores stream one per cycle, loads pause for the read.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (req_valid) begin
                    state_next = (req_multi && (req_reglist == 16'd0)) ? ST_DONE : ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (load_q) begin
                    state_next = ST_LOAD_WAIT;
                end else if (multi_q && (pick_remaining != 16'd0)) begin
                    state_next = ST_ACCESS;
                end else begin
                    state_next = ST_DONE;
                end
            end
            ST_LOAD_WAIT: begin
                state_next = (multi_q && (list_q != 16'd0)) ? ST_ACCESS : ST_DONE;
            end
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Request latch and per-transfer bookkeeping of address and pending list.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            load_q       <= 1'b0;
            byte_q       <= 1'b0;
            multi_q      <= 1'b0;
            addr_q       <= 32'd0;
            store_data_q <= 32'd0;
            rd_q         <= 4'd0;
            list_q       <= 16'd0;
            cur_reg_q    <= 4'd0;
            base_next_q  <= 32'd0;
        end else if (state == ST_IDLE && req_valid) begin
            load_q       <= req_load;
            byte_q       <= req_byte & ~req_multi;
            multi_q      <= req_multi;
            addr_q       <= req_multi ? start_addr : req_addr;
            store_data_q <= req_store_data;
            rd_q         <= req_rd;
            list_q       <= req_multi ? req_reglist : 16'd0;
            base_next_q  <= !req_multi ? req_addr :
                            (req_up ? req_addr + four_n : req_addr - four_n);
        end else if (state == ST_ACCESS && multi_q) begin
            list_q    <= pick_remaining;
            addr_q    <= addr_q + 32'd4;
            cur_reg_q <= pick_index;
        end
    end

    // Moore outputs: one enable in ACCESS, writeback in LOAD_WAIT, pulse in DONE.
    always_comb begin
        req_ready         = 1'b0;
        wb_valid          = 1'b0;
        wb_data           = 32'd0;
        done              = 1'b0;
        mem_write_word_en = 1'b0;
        mem_write_byte_en = 1'b0;
        mem_read_word_en  = 1'b0;
        mem_read_byte_en  = 1'b0;
        case (state)
            ST_IDLE: req_ready = 1'b1;
            ST_ACCESS: begin
                if (load_q) begin
                    mem_read_byte_en  = byte_q;
                    mem_read_word_en  = ~byte_q;
                end else begin
                    mem_write_byte_en = byte_q;
                    mem_write_word_en = ~byte_q;
                end
            end
            ST_LOAD_WAIT: begin
                wb_valid = 1'b1;
                if (byte_q) begin
                    wb_data = {24'd0, mem_read_byte_data};
                end else if (multi_q) begin
                    wb_data = mem_read_word_data;
                end else begin
                    case (addr_q[1:0])
                        2'd1:    wb_data = {mem_read_word_data[7:0],  mem_read_word_data[31:8]};
                        2'd2:    wb_data = {mem_read_word_data[15:0], mem_read_word_data[31:16]};
                        2'd3:    wb_data = {mem_read_word_data[23:0], mem_read_word_data[31:24]};
                        default: wb_data = mem_read_word_data;
                    endcase
                end
            end
            ST_DONE: done = 1'b1;
            default: req_ready = 1'b0;
        endcase
    end

    assign wb_reg                 = multi_q ? cur_reg_q : rd_q;
    assign base_next              = base_next_q;
    assign rf_rd_addr             = pick_index;
    assign mem_write_word_address = {addr_q[31:2], 2'b00};
    assign mem_read_word_address  = {addr_q[31:2], 2'b00};
    assign mem_write_byte_address = addr_q;
    assign mem_read_byte_address  = addr_q;
    assign mem_write_word_data    = multi_q ? rf_rd_data : store_data_q;
    assign mem_write_byte_data    = store_data_q[7:0];

endmodule

// File: tb/tb_arm7_load_store_unit.sv
// Directed bench for arm7_load_store_unit with a behavioural data_memory
// and register file, table-driven transfers plus hand-written sequences.
module tb_arm7_load_store_unit;

    localparam logic N = 1'b0;
    localparam logic Y = 1'b1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_load = 1'b0;
    logic        req_byte = 1'b0;
    logic        req_multi = 1'b0;
    logic        req_up = 1'b0;
    logic        req_pre = 1'b0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_store_data = 32'd0;
    logic [3:0]  req_rd = 4'd0;
    logic [15:0] req_reglist = 16'd0;
    logic [3:0]  rf_rd_addr;
    logic [31:0] rf_rd_data;
    logic        wb_valid;
    logic [3:0]  wb_reg;
    logic [31:0] wb_data;
    logic        done;
    logic [31:0] base_next;
    logic        mem_write_word_en, mem_write_byte_en, mem_read_word_en, mem_read_byte_en;
    logic [31:0] mem_write_word_address, mem_write_byte_address;
    logic [31:0] mem_read_word_address, mem_read_byte_address;
    logic [31:0] mem_write_word_data;
    logic [7:0]  mem_write_byte_data;
    logic [31:0] mem_read_word_data = 32'd0;
    logic [7:0]  mem_read_byte_data = 8'd0;

    logic [7:0]  mem [0:16383];
    logic [31:0] rf [16];

    int compared = 0;
    int mismatched = 0;

    typedef struct {
        string       name;
        logic        load, is_byte, multi, up, pre;
        logic [31:0] addr, sdata;
        logic [3:0]  rd;
        logic [15:0] list;
        int          exp_cycles;
        logic [31:0] exp_base;
        int          exp_wb;
        logic [3:0]  exp_first_reg;
        logic [31:0] exp_first_wb;
        logic [3:0]  exp_last_reg;
        logic [31:0] exp_last_wb;
        int          exp_wr;
        logic [31:0] exp_first_wr_addr, exp_last_wr_addr, exp_last_wr_data;
        logic [3:0]  exp_mask;
    } vec_t;

    vec_t vectors [13];

    int          obs_cycles, obs_wb, obs_wr, obs_multi_en, obs_busy_ready;
    logic [31:0] obs_base, obs_first_wb, obs_last_wb;
    logic [31:0] obs_first_wr_addr, obs_last_wr_addr, obs_last_wr_data;
    logic [3:0]  obs_first_reg, obs_last_reg, obs_mask;

    arm7_load_store_unit dut (
        .clk                    (clk),
        .rst_n                  (rst_n),
        .req_valid              (req_valid),
        .req_ready              (req_ready),
        .req_load               (req_load),
        .req_byte               (req_byte),
        .req_multi              (req_multi),
        .req_up                 (req_up),
        .req_pre                (req_pre),
        .req_addr               (req_addr),
        .req_store_data         (req_store_data),
        .req_rd                 (req_rd),
        .req_reglist            (req_reglist),
        .rf_rd_addr             (rf_rd_addr),
        .rf_rd_data             (rf_rd_data),
        .wb_valid               (wb_valid),
        .wb_reg                 (wb_reg),
        .wb_data                (wb_data),
        .done                   (done),
        .base_next              (base_next),
        .mem_write_word_en      (mem_write_word_en),
        .mem_write_byte_en      (mem_write_byte_en),
        .mem_read_word_en       (mem_read_word_en),
        .mem_read_byte_en       (mem_read_byte_en),
        .mem_write_word_address (mem_write_word_address),
        .mem_write_byte_address (mem_write_byte_address),
        .mem_read_word_address  (mem_read_word_address),
        .mem_read_byte_address  (mem_read_byte_address),
        .mem_write_word_data    (mem_write_word_data),
        .mem_write_byte_data    (mem_write_byte_data),
        .mem_read_word_data     (mem_read_word_data),
        .mem_read_byte_data     (mem_read_byte_data)
    );

    always #5 clk = ~clk;

    assign rf_rd_data = rf[rf_rd_addr];

    // Little-endian data_memory model: one-cycle read latency, data held.
    always @(posedge clk) begin
        if (mem_write_word_en) begin
            mem[{mem_write_word_address[13:2], 2'd0}] <= mem_write_word_data[7:0];
            mem[{mem_write_word_address[13:2], 2'd1}] <= mem_write_word_data[15:8];
            mem[{mem_write_word_address[13:2], 2'd2}] <= mem_write_word_data[23:16];
            mem[{mem_write_word_address[13:2], 2'd3}] <= mem_write_word_data[31:24];
        end
        if (mem_write_byte_en) begin
            mem[mem_write_byte_address[13:0]] <= mem_write_byte_data;
        end
        if (mem_read_word_en) begin
            mem_read_word_data <= {mem[{mem_read_word_address[13:2], 2'd3}],
                                   mem[{mem_read_word_address[13:2], 2'd2}],
                                   mem[{mem_read_word_address[13:2], 2'd1}],
                                   mem[{mem_read_word_address[13:2], 2'd0}]};
        end
        if (mem_read_byte_en) begin
            mem_read_byte_data <= mem[mem_read_byte_address[13:0]];
        end
    end

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic apply_stimulus(input vec_t v);
        int wait_cycles;
        @(negedge clk);
        req_valid      = 1'b1;
        req_load       = v.load;
        req_byte       = v.is_byte;
        req_multi      = v.multi;
        req_up         = v.up;
        req_pre        = v.pre;
        req_addr       = v.addr;
        req_store_data = v.sdata;
        req_rd         = v.rd;
        req_reglist    = v.list;
        obs_cycles = -1; obs_wb = 0; obs_wr = 0; obs_multi_en = 0; obs_busy_ready = 0;
        obs_base = 32'd0; obs_first_wb = 32'd0; obs_last_wb = 32'd0;
        obs_first_reg = 4'd0; obs_last_reg = 4'd0; obs_mask = 4'd0;
        obs_first_wr_addr = 32'd0; obs_last_wr_addr = 32'd0; obs_last_wr_data = 32'd0;
        wait_cycles = 0;
        while (!req_ready && wait_cycles < 20) begin
            @(negedge clk);
            wait_cycles++;
        end
        @(posedge clk);
        @(negedge clk);
        req_valid      = 1'b0;
        req_load       = ~v.load;
        req_multi      = ~v.multi;
        req_addr       = 32'h5A5A_5A5A;
        req_store_data = 32'hA5A5_A5A5;
        req_rd         = 4'hF;
        req_reglist    = 16'hFFFF;
        for (int c = 1; c <= 40; c++) begin
            if (req_ready) obs_busy_ready++;
            if ((32'(mem_write_word_en) + 32'(mem_write_byte_en) +
                 32'(mem_read_word_en) + 32'(mem_read_byte_en)) > 32'd1) obs_multi_en++;
            obs_mask = obs_mask | {mem_write_word_en, mem_write_byte_en, mem_read_word_en, mem_read_byte_en};
            if (wb_valid) begin
                if (obs_wb == 0) begin
                    obs_first_reg = wb_reg;
                    obs_first_wb  = wb_data;
                end
                obs_last_reg = wb_reg;
                obs_last_wb  = wb_data;
                obs_wb++;
            end
            if (mem_write_word_en || mem_write_byte_en) begin
                obs_last_wr_addr = mem_write_word_en ? mem_write_word_address : mem_write_byte_address;
                obs_last_wr_data = mem_write_word_en ? mem_write_word_data : {24'd0, mem_write_byte_data};
                if (obs_wr == 0) obs_first_wr_addr = obs_last_wr_addr;
                obs_wr++;
            end
            if (done) begin
                obs_cycles = c;
                obs_base   = base_next;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic check_vector(input vec_t v);
        check_output({v.name, ".done_cycle"}, obs_cycles, v.exp_cycles);
        check_output({v.name, ".base_next"}, obs_base, v.exp_base);
        check_output({v.name, ".wb_count"}, obs_wb, v.exp_wb);
        check_output({v.name, ".wr_count"}, obs_wr, v.exp_wr);
        check_output({v.name, ".enable_set"}, {28'd0, obs_mask}, {28'd0, v.exp_mask});
        check_output({v.name, ".multi_enable"}, obs_multi_en, 0);
        check_output({v.name, ".ready_busy"}, obs_busy_ready, 0);
        if (v.exp_wb > 0) begin
            check_output({v.name, ".first_wb_reg"}, {28'd0, obs_first_reg}, {28'd0, v.exp_first_reg});
            check_output({v.name, ".first_wb_data"}, obs_first_wb, v.exp_first_wb);
            check_output({v.name, ".last_wb_reg"}, {28'd0, obs_last_reg}, {28'd0, v.exp_last_reg});
            check_output({v.name, ".last_wb_data"}, obs_last_wb, v.exp_last_wb);
        end
        if (v.exp_wr > 0) begin
            check_output({v.name, ".first_wr_addr"}, obs_first_wr_addr, v.exp_first_wr_addr);
            check_output({v.name, ".last_wr_addr"}, obs_last_wr_addr, v.exp_last_wr_addr);
            check_output({v.name, ".last_wr_data"}, obs_last_wr_data, v.exp_last_wr_data);
        end
    endtask

    initial begin
        int done1, done2, wb_cycle, accepts, done_seen;
        logic [31:0] wb_d;
        logic [3:0]  wb_r;

        for (int i = 0; i < 16; i++) rf[i] = 32'd0;
        rf[0]  = 32'h0000_00A0;
        rf[1]  = 32'd1;
        rf[2]  = 32'd2;
        rf[3]  = 32'd3;
        rf[4]  = 32'h0000_0044;
        rf[15] = 32'h0000_00F0;

        vectors[0]  = '{"str_word",   N,N,N,N,N, 32'h0000_1000, 32'hDEAD_BEEF, 4'd0, 16'h0000, 2, 32'h0000_1000,
                        0, 4'd0, 32'h0, 4'd0, 32'h0, 1, 32'h0000_1000, 32'h0000_1000, 32'hDEAD_BEEF, 4'b1000};
        vectors[1]  = '{"ldr_aligned", Y,N,N,N,N, 32'h0000_1000, 32'h0, 4'd5, 16'h0000, 3, 32'h0000_1000,
                        1, 4'd5, 32'hDEAD_BEEF, 4'd5, 32'hDEAD_BEEF, 0, 32'h0, 32'h0, 32'h0, 4'b0010};
        vectors[2]  = '{"ldr_rot8",   Y,N,N,N,N, 32'h0000_1001, 32'h0, 4'd6, 16'h0000, 3, 32'h0000_1001,
                        1, 4'd6, 32'hEFDE_ADBE, 4'd6, 32'hEFDE_ADBE, 0, 32'h0, 32'h0, 32'h0, 4'b0010};
        vectors[3]  = '{"strb",       N,Y,N,N,N, 32'h0000_1001, 32'h1234_56AA, 4'd0, 16'h0000, 2, 32'h0000_1001,
                        0, 4'd0, 32'h0, 4'd0, 32'h0, 1, 32'h0000_1001, 32'h0000_1001, 32'h0000_00AA, 4'b0100};
        vectors[4]  = '{"ldrb",       Y,Y,N,N,N, 32'h0000_1001, 32'h0, 4'd7, 16'h0000, 3, 32'h0000_1001,
                        1, 4'd7, 32'h0000_00AA, 4'd7, 32'h0000_00AA, 0, 32'h0, 32'h0, 32'h0, 4'b0001};
        vectors[5]  = '{"ldr_after_strb", Y,N,N,N,N, 32'h0000_1000, 32'h0, 4'd8, 16'h0000, 3, 32'h0000_1000,
                        1, 4'd8, 32'hDEAD_AAEF, 4'd8, 32'hDEAD_AAEF, 0, 32'h0, 32'h0, 32'h0, 4'b0010};
        vectors[6]  = '{"ldr_rot24",  Y,N,N,N,N, 32'h0000_1003, 32'h0, 4'd9, 16'h0000, 3, 32'h0000_1003,
                        1, 4'd9, 32'hADAA_EFDE, 4'd9, 32'hADAA_EFDE, 0, 32'h0, 32'h0, 32'h0, 4'b0010};
        vectors[7]  = '{"stm_db",     N,N,Y,N,Y, 32'h0000_2000, 32'h0, 4'd0, 16'h000E, 4, 32'h0000_1FF4,
                        0, 4'd0, 32'h0, 4'd0, 32'h0, 3, 32'h0000_1FF4, 32'h0000_1FFC, 32'd3, 4'b1000};
        vectors[8]  = '{"ldm_ia",     Y,N,Y,Y,N, 32'h0000_1FF4, 32'h0, 4'd0, 16'h000E, 7, 32'h0000_2000,
                        3, 4'd1, 32'd1, 4'd3, 32'd3, 0, 32'h0, 32'h0, 32'h0, 4'b0010};
        vectors[9]  = '{"stm_empty",  N,N,Y,Y,N, 32'h0000_3000, 32'h0, 4'd0, 16'h0000, 1, 32'h0000_3000,
                        0, 4'd0, 32'h0, 4'd0, 32'h0, 0, 32'h0, 32'h0, 32'h0, 4'b0000};
        vectors[10] = '{"stm_ia_wrap", N,N,Y,Y,N, 32'hFFFF_FFF8, 32'h0, 4'd0, 16'h8003, 4, 32'h0000_0004,
                        0, 4'd0, 32'h0, 4'd0, 32'h0, 3, 32'hFFFF_FFF8, 32'h0000_0000, 32'h0000_00F0, 4'b1000};
        vectors[11] = '{"ldm_ib_wrap", Y,N,Y,Y,Y, 32'hFFFF_FFF4, 32'h0, 4'd0, 16'h0007, 7, 32'h0000_0000,
                        3, 4'd0, 32'h0000_00A0, 4'd2, 32'h0000_00F0, 0, 32'h0, 32'h0, 32'h0, 4'b0010};
        vectors[12] = '{"stm_da_one", N,N,Y,N,N, 32'h0000_3010, 32'h0, 4'd0, 16'h0010, 2, 32'h0000_300C,
                        0, 4'd0, 32'h0, 4'd0, 32'h0, 1, 32'h0000_3010, 32'h0000_3010, 32'h0000_0044, 4'b1000};

        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_output("reset.req_ready", {31'd0, req_ready}, 32'd1);
        check_output("reset.enables", {28'd0, mem_write_word_en, mem_write_byte_en, mem_read_word_en, mem_read_byte_en}, 32'd0);
        check_output("reset.wb_done", {30'd0, wb_valid, done}, 32'd0);
        check_output("reset.rf_rd_addr", {28'd0, rf_rd_addr}, 32'd0);
        check_output("reset.base_next", base_next, 32'd0);
        check_output("reset.word_addr", mem_write_word_address | mem_read_word_address, 32'd0);
        check_output("reset.wr_data", mem_write_word_data, 32'd0);

        for (int i = 0; i < 13; i++) begin
            apply_stimulus(vectors[i]);
            check_vector(vectors[i]);
        end

        // Back-to-back: a held request is accepted only the cycle after done.
        @(negedge clk);
        req_valid = 1'b1; req_load = 1'b0; req_byte = 1'b0; req_multi = 1'b0;
        req_addr = 32'h0000_1100; req_store_data = 32'h1111_1111; req_rd = 4'd0; req_reglist = 16'd0;
        done1 = -1; done2 = -1; wb_cycle = -1; accepts = 0; wb_d = 32'd0; wb_r = 4'd0;
        for (int c = 0; c < 12; c++) begin
            if (req_valid && req_ready) accepts++;
            if (done) begin
                if (done1 < 0) done1 = c;
                else if (done2 < 0) done2 = c;
            end
            if (wb_valid) begin
                wb_cycle = c; wb_d = wb_data; wb_r = wb_reg;
            end
            @(negedge clk);
            if (c == 0) begin
                req_load = 1'b1; req_rd = 4'd10; req_store_data = 32'h0;
            end
            if (c == 3) req_valid = 1'b0;
        end
        check_output("b2b.accepts", accepts, 2);
        check_output("b2b.store_done", done1, 2);
        check_output("b2b.load_done", done2, 6);
        check_output("b2b.wb_cycle", wb_cycle, 5);
        check_output("b2b.wb_data", wb_d, 32'h1111_1111);
        check_output("b2b.wb_reg", {28'd0, wb_r}, 32'd10);

        // Reset in the middle of an LDM drops enables at once and issues no done.
        @(negedge clk);
        req_valid = 1'b1; req_load = 1'b1; req_multi = 1'b1; req_up = 1'b1; req_pre = 1'b0;
        req_addr = 32'h0000_1FF4; req_reglist = 16'h000E;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        check_output("rst_mid.access_en", {31'd0, mem_read_word_en}, 32'd1);
        @(negedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_output("rst_mid.enables", {28'd0, mem_write_word_en, mem_write_byte_en, mem_read_word_en, mem_read_byte_en}, 32'd0);
        check_output("rst_mid.wb_valid", {31'd0, wb_valid}, 32'd0);
        check_output("rst_mid.ready_in_reset", {31'd0, req_ready}, 32'd1);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        done_seen = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (done) done_seen++;
        end
        check_output("rst_mid.no_done", done_seen, 0);
        check_output("rst_mid.ready_after", {31'd0, req_ready}, 32'd1);

        apply_stimulus(vectors[5]);
        check_vector(vectors[5]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    // Hard stop so a hung DUT still ends the run.
    initial begin
        #200000;
        $display("[TB] FAIL timeout: got no end of test, expected completion");
        $fatal(1, "[TB] timeout");
    end

endmodule
